// File: rtl/axi_ram_slave.sv
// axi_ram_slave: single-beat AXI slave backed by a 2^ADDR_W x 32 word RAM.
// Read and write channels run independent FSMs with optional stall cycles.
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   ar* / r*               read address / read data channels (arlen, arsize, arburst ignored)
//   aw* / w* / b*          write address / write data / write response channels (wlast ignored)
module axi_ram_slave #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned RD_WAIT = 0,
  parameter int unsigned WR_WAIT = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam logic [3:0]  RD_LOAD = 4'(RD_WAIT);
  // W_WAIT spans WR_WAIT cycles, so the counter starts one below it
  localparam logic [3:0]  WR_LOAD = (WR_WAIT == 0) ? 4'd0 : 4'(WR_WAIT - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_WAIT, W_RESP} wstate_t;

  logic [31:0]       mem [DEPTH];

  rstate_t           rstate;
  logic [3:0]        rcnt;
  logic [ADDR_W-1:0] ridx;

  wstate_t           wstate;
  logic [3:0]        wcnt;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_held;
  logic              w_held;

  logic              aw_hs;
  logic              w_hs;
  logic              unused_ok;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Burst/size fields, wlast and non-index address bits are intentionally ignored
  assign unused_ok = ^{arlen, arsize, arburst, wlast,
                       araddr[31:ADDR_W+2], araddr[1:0],
                       awaddr[31:ADDR_W+2], awaddr[1:0]};

  // Read FSM: accept AR, wait 1+RD_WAIT cycles, present one beat until rready
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rstate  <= R_IDLE;
      rcnt    <= 4'd0;
      ridx    <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rid     <= 4'd0;
      rdata   <= 32'd0;
      rresp   <= 2'b00;
      rlast   <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (arvalid && arready) begin
            rid     <= arid;
            ridx    <= araddr[ADDR_W+1:2];
            rcnt    <= RD_LOAD;
            arready <= 1'b0;
            rstate  <= R_WAIT;
          end else begin
            arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (rcnt == 4'd0) begin
            // Same edge as a W_WRITE to this word: the non-blocking read sees old data
            rdata  <= mem[ridx];
            rvalid <= 1'b1;
            rlast  <= 1'b1;
            rstate <= R_RESP;
          end else begin
            rcnt <= rcnt - 4'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
            rstate  <= R_IDLE;
          end
        end
        default: begin
          arready <= 1'b0;
          rvalid  <= 1'b0;
          rstate  <= R_IDLE;
        end
      endcase
    end
  end

  // Write FSM: capture AW and W in any order, write once, optional wait, respond
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wstate  <= W_IDLE;
      wcnt    <= 4'd0;
      widx    <= '0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= 4'd0;
      bresp   <= 2'b00;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            bid     <= awid;
            widx    <= awaddr[ADDR_W+1:2];
            aw_held <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            w_held  <= 1'b1;
          end
          // Each ready stays high only until its own channel has been captured
          awready <= !(aw_held || aw_hs);
          wready  <= !(w_held || w_hs);
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            wstate <= W_WRITE;
          end
        end
        W_WRITE: begin
          if (WR_WAIT == 0) begin
            bvalid <= 1'b1;
            wstate <= W_RESP;
          end else begin
            wcnt   <= WR_LOAD;
            wstate <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wcnt == 4'd0) begin
            bvalid <= 1'b1;
            wstate <= W_RESP;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: begin
          awready <= 1'b0;
          wready  <= 1'b0;
          bvalid  <= 1'b0;
          wstate  <= W_IDLE;
        end
      endcase
    end
  end

  // RAM write port: byte-masked, suppressed on a reset edge so no partial write lands
  always_ff @(posedge aclk) begin
    if (aresetn && (wstate == W_WRITE)) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem[widx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed self-checking bench for axi_ram_slave.
// dut uses default parameters; dut3 uses RD_WAIT=3, WR_WAIT=2 for stall timing.
module tb_axi_ram_slave;

  logic        clk;
  logic        aresetn, aresetn3;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  arlen, wstrb;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        wlast;

  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  logic        arvalid3, rready3, awvalid3, wvalid3, bready3;
  logic        arready3, rlast3, rvalid3, awready3, wready3, bvalid3;
  logic [3:0]  rid3, bid3;
  logic [31:0] rdata3;
  logic [1:0]  rresp3, bresp3;

  int n_tests = 0;
  int n_fail  = 0;

  axi_ram_slave dut (
    .aclk(clk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_ram_slave #(.ADDR_W(12), .RD_WAIT(3), .WR_WAIT(2)) dut3 (
    .aclk(clk), .aresetn(aresetn3),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid3), .arready(arready3),
    .rid(rid3), .rdata(rdata3), .rresp(rresp3), .rlast(rlast3), .rvalid(rvalid3), .rready(rready3),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid3), .awready(awready3),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid3), .wready(wready3),
    .bid(bid3), .bresp(bresp3), .bvalid(bvalid3), .bready(bready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single read on dut with bounded waits; ok=0 on timeout
  task automatic rd(input logic [31:0] a, input logic [3:0] id,
                    output logic [31:0] d, output logic ok);
    logic acc;
    acc = 1'b0; ok = 1'b0; d = 'x;
    araddr = a; arid = id; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      acc = arready;
      tick();
      if (acc) break;
    end
    arvalid = 1'b0;
    if (acc) begin
      for (int i = 0; i < 30; i++) begin
        if (rvalid) begin
          d = rdata; ok = 1'b1;
          tick();
          break;
        end
        tick();
      end
    end
  endtask

  // Single write on dut (AW and W together) with bounded waits; ok=0 on timeout
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [3:0] id, output logic ok);
    logic ra, rw;
    ok = 1'b0;
    awaddr = a; awid = id; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = awready; rw = wready;
      tick();
      if (ra) awvalid = 1'b0;
      if (rw) wvalid = 1'b0;
      if (!awvalid && !wvalid) break;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bvalid) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; aresetn3 = 1'b0;
    arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;
    arvalid3 = 0; rready3 = 0; awvalid3 = 0; wvalid3 = 0; bready3 = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01;
    awid = 0; awaddr = 0; wdata = 0; wstrb = 0; wlast = 1'b1;
    tick(); tick();
    n_tests++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ready_valid: got %b want 00000", {arready, awready, wready, rvalid, bvalid});
    end
    n_tests++;
    if ({rid, bid, rresp, bresp, rlast, rdata} !== 45'd0) begin
      n_fail++;
      $display("FAIL reset_payload: got %h want 0", {rid, bid, rresp, bresp, rlast, rdata});
    end
    aresetn = 1'b1; aresetn3 = 1'b1;
    tick();
    n_tests++;
    if ({arready, awready, wready, arready3, awready3, wready3} !== 6'b111111) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 111111",
               {arready, awready, wready, arready3, awready3, wready3});
    end
  endtask

  task automatic test_write_same_cycle();
    awaddr = 32'h10; awid = 4'd1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n_tests++;
    if ({bvalid, awready, wready} !== 3'b000) begin
      n_fail++;
      $display("FAIL wr_n1: got bvalid/awready/wready=%b want 000", {bvalid, awready, wready});
    end
    tick();
    n_tests++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd1, 2'b00}) begin
      n_fail++;
      $display("FAIL wr_resp: got bvalid=%b bid=%0d bresp=%0d want 1/1/0", bvalid, bid, bresp);
    end
    tick();
    n_tests++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      n_fail++;
      $display("FAIL wr_done: got bvalid/awready/wready=%b want 011", {bvalid, awready, wready});
    end
  endtask

  task automatic test_read();
    araddr = 32'h10; arid = 4'd1; arlen = 4'd7; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    n_tests++;
    if ({rvalid, arready} !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_n1: got rvalid/arready=%b want 00", {rvalid, arready});
    end
    tick();
    n_tests++;
    if ({rvalid, rid, rresp, rlast, rdata} !== {1'b1, 4'd1, 2'b00, 1'b1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL rd_beat: got rvalid=%b rid=%0d rresp=%0d rlast=%b rdata=%h want 1/1/0/1/deadbeef",
               rvalid, rid, rresp, rlast, rdata);
    end
    tick();
    arlen = 4'd0;
    n_tests++;
    if ({rvalid, arready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rd_done: got rvalid/arready=%b want 01", {rvalid, arready});
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic ok;
    wdata = 32'h0000AA00; wstrb = 4'b0010; wvalid = 1'b1; bready = 1'b1;
    tick();
    wvalid = 1'b0;
    n_tests++;
    if ({wready, awready, bvalid} !== 3'b010) begin
      n_fail++;
      $display("FAIL w_first_ready: got wready/awready/bvalid=%b want 010", {wready, awready, bvalid});
    end
    tick(); tick();
    awaddr = 32'h10; awid = 4'd2; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    n_tests++;
    if ({bvalid, bid} !== {1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL w_first_resp: got bvalid=%b bid=%0d want 1/2", bvalid, bid);
    end
    tick();
    rd(32'h10, 4'd0, d, ok);
    n_tests++;
    if (!ok || d !== 32'hDEADAAEF) begin
      n_fail++;
      $display("FAIL w_first_data: got ok=%b data=%h want 1/deadaaef", ok, d);
    end
  endtask

  task automatic test_rready_stall();
    araddr = 32'h10; arid = 4'd3; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    tick();
    n_tests++;
    if ({rvalid, rid, rdata} !== {1'b1, 4'd3, 32'hDEADAAEF}) begin
      n_fail++;
      $display("FAIL stall_first: got rvalid=%b rid=%0d rdata=%h want 1/3/deadaaef", rvalid, rid, rdata);
    end
    araddr = 32'h20; arid = 4'd4; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({rvalid, arready, rid, rdata} !== {2'b10, 4'd3, 32'hDEADAAEF}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got rvalid=%b arready=%b rid=%0d rdata=%h want 1/0/3/deadaaef",
                 i, rvalid, arready, rid, rdata);
      end
    end
    arvalid = 1'b0; rready = 1'b1;
    tick();
    n_tests++;
    if ({rvalid, arready} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_release: got rvalid/arready=%b want 01", {rvalid, arready});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_no_accept[%0d]: got rvalid=%b want 0", i, rvalid);
      end
    end
  endtask

  task automatic test_same_word();
    logic [31:0] d;
    logic ok;
    wr(32'h20, 32'h11111111, 4'hF, 4'd4, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL same_pre_write: got ok=%b want 1", ok);
    end
    araddr = 32'h20; arid = 4'd5; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h20; awid = 4'd6; wdata = 32'h22222222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n_tests++;
    if ({arready, awready, wready} !== 3'b111) begin
      n_fail++;
      $display("FAIL same_ready: got %b want 111", {arready, awready, wready});
    end
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    tick();
    n_tests++;
    if ({rvalid, rdata, bvalid, bid} !== {1'b1, 32'h11111111, 1'b1, 4'd6}) begin
      n_fail++;
      $display("FAIL same_old_data: got rvalid=%b rdata=%h bvalid=%b bid=%0d want 1/11111111/1/6",
               rvalid, rdata, bvalid, bid);
    end
    tick();
    rd(32'h20, 4'd7, d, ok);
    n_tests++;
    if (!ok || d !== 32'h22222222) begin
      n_fail++;
      $display("FAIL same_new_data: got ok=%b data=%h want 1/22222222", ok, d);
    end
    // bit 14 and addr[1:0] lie outside the word index
    rd(32'h4023, 4'd7, d, ok);
    n_tests++;
    if (!ok || d !== 32'h22222222) begin
      n_fail++;
      $display("FAIL alias: got ok=%b data=%h want 1/22222222", ok, d);
    end
  endtask

  task automatic test_wstrb();
    logic [31:0] d;
    logic ok;
    wr(32'h20, 32'hFFFFFFFF, 4'b0000, 4'd8, ok);
    rd(32'h20, 4'd0, d, ok);
    n_tests++;
    if (!ok || d !== 32'h22222222) begin
      n_fail++;
      $display("FAIL wstrb_zero: got ok=%b data=%h want 1/22222222", ok, d);
    end
    wr(32'h20, 32'h99000000, 4'b1000, 4'd8, ok);
    rd(32'h20, 4'd0, d, ok);
    n_tests++;
    if (!ok || d !== 32'h99222222) begin
      n_fail++;
      $display("FAIL wstrb_top: got ok=%b data=%h want 1/99222222", ok, d);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    logic ok;
    awaddr = 32'h20; awid = 4'd9; wdata = 32'h33333333; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    n_tests++;
    if ({bvalid, awready} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstw_in_reset: got bvalid/awready=%b want 00", {bvalid, awready});
    end
    tick();
    n_tests++;
    if ({arready, awready, wready, bvalid} !== 4'b1110) begin
      n_fail++;
      $display("FAIL rstw_release: got %b want 1110", {arready, awready, wready, bvalid});
    end
    rd(32'h20, 4'd0, d, ok);
    n_tests++;
    if (!ok || d !== 32'h99222222) begin
      n_fail++;
      $display("FAIL rstw_no_write: got ok=%b data=%h want 1/99222222", ok, d);
    end
    rd(32'h10, 4'd0, d, ok);
    n_tests++;
    if (!ok || d !== 32'hDEADAAEF) begin
      n_fail++;
      $display("FAIL rstw_mem_kept: got ok=%b data=%h want 1/deadaaef", ok, d);
    end
  endtask

  task automatic test_wait_states();
    awaddr = 32'h40; awid = 4'd7; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid3 = 1'b1; wvalid3 = 1'b1; bready3 = 1'b1;
    tick();
    awvalid3 = 1'b0; wvalid3 = 1'b0;
    // AW/W at cycle N -> W_WRITE N+1, W_WAIT N+2..N+3, bvalid N+4
    for (int c = 1; c <= 4; c++) begin
      n_tests++;
      if (bvalid3 !== (c == 4)) begin
        n_fail++;
        $display("FAIL wwait_n%0d: got bvalid=%b want %b", c, bvalid3, (c == 4));
      end
      if (c < 4) tick();
    end
    n_tests++;
    if (bid3 !== 4'd7) begin
      n_fail++;
      $display("FAIL wwait_bid: got %0d want 7", bid3);
    end
    tick();
    araddr = 32'h40; arid = 4'd9; arvalid3 = 1'b1; rready3 = 1'b1;
    tick();
    arvalid3 = 1'b0;
    // AR at cycle N -> R_WAIT N+1..N+4, rvalid N+5
    for (int c = 1; c <= 5; c++) begin
      n_tests++;
      if (rvalid3 !== (c == 5)) begin
        n_fail++;
        $display("FAIL rwait_n%0d: got rvalid=%b want %b", c, rvalid3, (c == 5));
      end
      if (c < 5) tick();
    end
    n_tests++;
    if ({rdata3, rid3, rlast3} !== {32'hCAFEF00D, 4'd9, 1'b1}) begin
      n_fail++;
      $display("FAIL rwait_beat: got rdata=%h rid=%0d rlast=%b want cafef00d/9/1", rdata3, rid3, rlast3);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    araddr = 32'h40; arid = 4'd2; arvalid3 = 1'b1; rready3 = 1'b1;
    tick();
    arvalid3 = 1'b0;
    tick();
    aresetn3 = 1'b0;
    tick();
    aresetn3 = 1'b1;
    tick();
    n_tests++;
    if ({arready3, rvalid3} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstr_release: got arready/rvalid=%b want 10", {arready3, rvalid3});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (rvalid3 !== 1'b0) begin
        n_fail++;
        $display("FAIL rstr_no_resp[%0d]: got rvalid=%b want 0", i, rvalid3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_read();
    test_w_before_aw();
    test_rready_stall();
    test_same_word();
    test_wstrb();
    test_reset_mid_write();
    test_wait_states();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
